// File: rtl/err_countdown_timer_pkg.sv
// Shared definitions for the error countdown timer.
//   - calc FSM state constant for the error state that starts the countdown
//   - timer state encoding
//   - default load / clamp ceiling values
//   - load_value(): picks the countdown length from cfg_sec
package err_countdown_timer_pkg;

    localparam logic [3:0] STATE_CALC_ERROR = 4'd14;

    localparam int DEFAULT_SEC_DEF = 10;
    localparam int MAX_SEC_DEF     = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_EXPIRE = 2'd2
    } timer_state_e;

    // cfg == 0 selects the default; anything else is clamped to max_sec.
    function automatic logic [3:0] load_value(input logic [3:0] cfg,
                                              input logic [3:0] dflt,
                                              input logic [3:0] max_sec);
        if (cfg == 4'd0) begin
            return dflt;
        end else if (cfg > max_sec) begin
            return max_sec;
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/err_countdown_timer_tick_prescaler.sv
// Second-tick prescaler.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   clr   in  synchronous clear back to 0 (takes priority over counting)
//   en    in  count enable; counter held at 0 while low
//   tick  out high during the wrap cycle (count == TICK_DIV-1), combinational
module err_countdown_timer_tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A clear in the wrap cycle swallows the tick.
    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/err_countdown_timer.sv
// Seconds countdown for the "Err XX" display.
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   start     in  one-cycle pulse: load and (re)start
//   abort     in  stop immediately, clear count (beats start)
//   cfg_sec   in  countdown length, 0 selects DEFAULT_SEC
//   time_left out remaining whole seconds (registered)
//   busy      out high while RUN (registered)
//   expired   out one-cycle pulse when the count reaches 0 (registered)
//   sec_tick  out one-cycle pulse per second boundary while RUN (registered)
//
// state  | meaning
// IDLE   | waiting for start, time_left holds last value
// RUN    | counting down one per TICK_DIV clocks
// EXPIRE | single cycle after reaching 0, expired high
module err_countdown_timer
    import err_countdown_timer_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_DIV    = CLK_HZ,
    parameter int DEFAULT_SEC = DEFAULT_SEC_DEF,
    parameter int MAX_SEC     = MAX_SEC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] cfg_sec,
    output logic [3:0] time_left,
    output logic       busy,
    output logic       expired,
    output logic       sec_tick
);

    localparam logic [3:0] DEF4 = 4'(DEFAULT_SEC);
    localparam logic [3:0] MAX4 = 4'(MAX_SEC);

    timer_state_e state;
    logic [3:0]   load_l;
    logic         tick;

    assign load_l = load_value(cfg_sec, DEF4, MAX4);

    err_countdown_timer_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (abort || start),
        .en   (state == ST_RUN),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            time_left <= 4'd0;
            busy      <= 1'b0;
            expired   <= 1'b0;
            sec_tick  <= 1'b0;
        end else begin
            expired  <= 1'b0;
            sec_tick <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                time_left <= 4'd0;
                busy      <= 1'b0;
            end else if (start) begin
                // A tick coinciding with start is dropped: no decrement, fresh load.
                if (load_l != 4'd0) begin
                    state     <= ST_RUN;
                    time_left <= load_l;
                    busy      <= 1'b1;
                end else begin
                    state     <= ST_EXPIRE;
                    time_left <= 4'd0;
                    busy      <= 1'b0;
                    expired   <= 1'b1;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (tick) begin
                            sec_tick <= 1'b1;
                            if (time_left <= 4'd1) begin
                                time_left <= 4'd0;
                                state     <= ST_EXPIRE;
                                busy      <= 1'b0;
                                expired   <= 1'b1;
                            end else begin
                                time_left <= time_left - 4'd1;
                            end
                        end
                    end
                    ST_EXPIRE: state <= ST_IDLE;
                    ST_IDLE:   state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
